// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: receive-side byte buffer downstream of the UART receiver.
// Captures each completed receiver byte into a DEPTH-entry circular FIFO,
// releases the receiver with a one-cycle rx_rdy_clr pulse, and presents
// buffered bytes on a first-word-fall-through valid/ready stream.
// Optional feature macro: UART_RX_FIFO_OVERRUN_EN enables the sticky overrun flag.
module uart_rx_fifo #(
    parameter int DEPTH = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       rx_rdy,
    input  logic [7:0]                 rx_data,
    output logic                       rx_rdy_clr,
    output logic [7:0]                 m_data,
    output logic                       m_valid,
    input  logic                       m_ready,
    output logic [$clog2(DEPTH):0]     level,
    output logic                       overrun,
    input  logic                       overrun_clr
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_LEVEL = (AW+1)'(DEPTH);

    typedef enum logic {
        IDLE = 1'b0,
        ACK  = 1'b1
    } state_t;

    state_t        state_q;
    state_t        state_d;
    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          push_req;
    logic          push_ok;
    logic          pop;
    logic          drop;

    // Capture handshake: a byte is taken only from IDLE; ACK lasts one cycle.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path infers a latch.
        state_d  = IDLE;
        push_req = 1'b0;
        if (state_q == IDLE && rx_rdy) begin
            push_req = 1'b1;
            state_d  = ACK;
        end
    end

    assign pop     = m_valid && m_ready;
    // A full FIFO can still accept when the head leaves on the same edge.
    assign push_ok = push_req && ((level < FULL_LEVEL) || pop);
    assign drop    = push_req && !push_ok;

    // FSM state register; rx_rdy_clr is decoded straight from this flop.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update together.
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    assign rx_rdy_clr = (state_q == ACK);

    // Byte storage write port.
    always_ff @(posedge clk) begin
        // NOTE: storage is deliberately not reset; validity is tracked by level alone.
        if (push_ok) begin
            mem[wr_ptr] <= rx_data;
        end
    end

    // Pointers and fill level; push and pop on the same edge leave level unchanged.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            if (push_ok && !pop) begin
                level <= level + (AW+1)'(1);
            end else if (pop && !push_ok) begin
                level <= level - (AW+1)'(1);
            end
        end
    end

    assign m_valid = (level != '0);
    assign m_data  = m_valid ? mem[rd_ptr] : 8'h00;

`ifdef UART_RX_FIFO_OVERRUN_EN
    // Sticky overrun flag: a dropped byte wins over a simultaneous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overrun <= 1'b0;
        end else if (drop) begin
            overrun <= 1'b1;
        end else if (overrun_clr) begin
            overrun <= 1'b0;
        end
    end
`else
    // Overrun reporting disabled: full-FIFO bytes are dropped silently.
    assign overrun = 1'b0;
    logic unused_overrun;
    assign unused_overrun = overrun_clr ^ drop;
`endif

endmodule
